// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller.
// Combines three requests into the 6-bit stall bus and the flush line:
// flush_req (highest priority), the EX multi-cycle busy, and the load-use hazard.
// stall and flush are combinational, so they act in the same cycle as the request.
// Optional build macro STALL_PERF_EN enables the stall-cycle performance counters.
// When it is not defined, both counters read 0 and perf_clr is ignored.
module pipe_stall_ctrl #(
  parameter int MAX_EX_HOLD  = 64,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_for_load,
  input  logic        stallreq_for_ex,
  input  logic        flush_req,
  output logic [5:0]  stall,
  output logic        flush,
  output logic        in_load_bubble,
  output logic        hold_timeout,
  input  logic        perf_clr,
  output logic [31:0] load_stall_cnt,
  output logic [31:0] ex_stall_cnt
);

  localparam int         HOLD_W       = $clog2(MAX_EX_HOLD + 1);
  localparam logic [5:0] STALL_NONE   = 6'b000000;
  localparam logic [5:0] STALL_LOAD   = 6'b000111;
  localparam logic [5:0] STALL_EXH    = 6'b001111;
  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_EX_HOLD);

  typedef enum logic [1:0] {RUN, LOAD_BUB, EX_HOLD, FLUSH} state_t;

  state_t            state, state_nxt;
  logic [3:0]        flush_cnt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic [5:0]        stall_c;
  logic              flush_c, bubble_c;
  logic              flush_load, flush_dec, timeout_set;

  // Next-state and request arbitration; flush_req wins from every state.
  always_comb begin
    state_nxt   = state;
    stall_c     = STALL_NONE;
    flush_c     = 1'b0;
    bubble_c    = (state == LOAD_BUB);
    flush_load  = 1'b0;
    flush_dec   = 1'b0;
    hold_nxt    = hold_cnt;
    timeout_set = 1'b0;
    if (flush_req) begin
      flush_c    = 1'b1;
      flush_load = 1'b1;
      state_nxt  = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
    end else begin
      case (state)
        RUN: begin
          if (stallreq_for_ex) begin
            stall_c   = STALL_EXH;
            hold_nxt  = HOLD_W'(1);
            state_nxt = EX_HOLD;
          end else if (stallreq_for_load) begin
            stall_c   = STALL_LOAD;
            state_nxt = LOAD_BUB;
          end
        end
        LOAD_BUB: begin
          // The load now sits in MEM and forwards, so its request is masked.
          if (stallreq_for_ex) begin
            stall_c   = STALL_EXH;
            hold_nxt  = HOLD_W'(1);
            state_nxt = EX_HOLD;
          end else begin
            state_nxt = RUN;
          end
        end
        EX_HOLD: begin
          // A load request on the release cycle is ignored; EX re-evaluates next cycle.
          if (stallreq_for_ex) begin
            stall_c  = STALL_EXH;
            hold_nxt = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + HOLD_W'(1);
          end else begin
            state_nxt = RUN;
          end
        end
        FLUSH: begin
          flush_c   = 1'b1;
          flush_dec = (flush_cnt != 4'd0);
          if (flush_cnt <= 4'd1) state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
    // Timeout is raised once the hold count reaches the limit with EX still busy.
    if (stall_c == STALL_EXH && hold_nxt == HOLD_MAX) timeout_set = 1'b1;
  end

  // State, flush/hold counters and the sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= RUN;
      flush_cnt    <= 4'd0;
      hold_cnt     <= '0;
      hold_timeout <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      if (flush_load)     flush_cnt <= FLUSH_RELOAD;
      else if (flush_dec) flush_cnt <= flush_cnt - 4'd1;
      if (timeout_set) hold_timeout <= 1'b1;
    end
  end

  assign stall          = rst ? stall_c  : STALL_NONE;
  assign flush          = rst ? flush_c  : 1'b0;
  assign in_load_bubble = rst ? bubble_c : 1'b0;

`ifdef STALL_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Stall-cycle counters; clear has priority over increment.
  always_ff @(posedge clk) begin
    if (!rst || perf_clr) begin
      load_stall_cnt <= 32'd0;
      ex_stall_cnt   <= 32'd0;
    end else begin
      if (stall == STALL_LOAD) load_stall_cnt <= sat_inc(load_stall_cnt);
      if (stall == STALL_EXH)  ex_stall_cnt   <= sat_inc(ex_stall_cnt);
    end
  end
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign load_stall_cnt  = 32'd0;
  assign ex_stall_cnt    = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed testbench for pipe_stall_ctrl (MAX_EX_HOLD=4, FLUSH_CYCLES=2).
module tb_pipe_stall_ctrl;

`ifdef STALL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_for_load, stallreq_for_ex, flush_req, perf_clr;
  logic [5:0]  stall;
  logic        flush, in_load_bubble, hold_timeout;
  logic [31:0] load_stall_cnt, ex_stall_cnt;

  int total  = 0;
  int passed = 0;

  pipe_stall_ctrl #(.MAX_EX_HOLD(4), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .stallreq_for_load(stallreq_for_load), .stallreq_for_ex(stallreq_for_ex),
    .flush_req(flush_req), .stall(stall), .flush(flush),
    .in_load_bubble(in_load_bubble), .hold_timeout(hold_timeout),
    .perf_clr(perf_clr), .load_stall_cnt(load_stall_cnt), .ex_stall_cnt(ex_stall_cnt)
  );

  always #5 clk = ~clk;

  // Drive a cycle's inputs just after the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic ld, input logic ex, input logic fr);
    @(negedge clk);
    stallreq_for_load = ld;
    stallreq_for_ex   = ex;
    flush_req         = fr;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; perf_clr = 1'b0;
    stallreq_for_load = 1'b0; stallreq_for_ex = 1'b0; flush_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; perf_clr = 1'b0;
    stallreq_for_load = 1'b1; stallreq_for_ex = 1'b1; flush_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({stall, flush, in_load_bubble, hold_timeout} !== 9'b0)
        $display("FAIL reset_outputs cycle %0d: stall=%b flush=%b bub=%b to=%b, want all 0",
                 i, stall, flush, in_load_bubble, hold_timeout);
      else passed++;
      @(negedge clk);
    end
    #1;
    total++;
    if (load_stall_cnt !== 32'd0 || ex_stall_cnt !== 32'd0)
      $display("FAIL reset_counters: load=%0d ex=%0d, want 0 0", load_stall_cnt, ex_stall_cnt);
    else passed++;
    stallreq_for_load = 1'b0; stallreq_for_ex = 1'b0; flush_req = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_load_use();
    logic [5:0] exp_stall [5] = '{6'b000111, 6'b000000, 6'b000111, 6'b000000, 6'b000000};
    logic       exp_bub   [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       ld        [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(ld[i], 1'b0, 1'b0);
      total++;
      if (stall !== exp_stall[i] || in_load_bubble !== exp_bub[i] || flush !== 1'b0)
        $display("FAIL load_use cycle %0d: stall=%b bub=%b flush=%b, want stall=%b bub=%b flush=0",
                 i, stall, in_load_bubble, flush, exp_stall[i], exp_bub[i]);
      else passed++;
    end
    total++;
    if (load_stall_cnt !== (PERF ? 32'd2 : 32'd0))
      $display("FAIL load_use_cnt: got %0d want %0d", load_stall_cnt, PERF ? 2 : 0);
    else passed++;
  endtask

  task automatic test_ex_hold();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      total++;
      if (stall !== 6'b001111 || in_load_bubble !== 1'b0)
        $display("FAIL ex_hold cycle %0d: stall=%b bub=%b, want 001111 0", i, stall, in_load_bubble);
      else passed++;
    end
    drive(1'b1, 1'b0, 1'b0);
    total++;
    if (stall !== 6'b000000)
      $display("FAIL ex_release: stall=%b want 000000", stall);
    else passed++;
    drive(1'b0, 1'b0, 1'b0);
    total++;
    if (ex_stall_cnt !== (PERF ? 32'd5 : 32'd0) || load_stall_cnt !== 32'd0)
      $display("FAIL ex_hold_cnt: ex=%0d load=%0d, want ex=%0d load=0",
               ex_stall_cnt, load_stall_cnt, PERF ? 5 : 0);
    else passed++;
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      total++;
      if (hold_timeout !== (i >= 4) || stall !== 6'b001111)
        $display("FAIL timeout cycle %0d: to=%b stall=%b, want to=%b stall=001111",
                 i, hold_timeout, stall, (i >= 4));
      else passed++;
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0);
      total++;
      if (hold_timeout !== 1'b1)
        $display("FAIL timeout_sticky cycle %0d: to=%b want 1", i, hold_timeout);
      else passed++;
    end
  endtask

  task automatic test_flush();
    logic       ex [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       fr [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       ef [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [5:0] es [5] = '{6'b001111, 6'b001111, 6'b000000, 6'b000000, 6'b000000};
    logic       fr2 [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic       ef2 [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, ex[i], fr[i]);
      total++;
      if (flush !== ef[i] || stall !== es[i])
        $display("FAIL flush_prio cycle %0d: flush=%b stall=%b, want flush=%b stall=%b",
                 i, flush, stall, ef[i], es[i]);
      else passed++;
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, fr2[i]);
      total++;
      if (flush !== ef2[i] || (ef2[i] && stall !== 6'b000000))
        $display("FAIL flush_extend cycle %0d: flush=%b stall=%b, want flush=%b",
                 i, flush, stall, ef2[i]);
      else passed++;
    end
  endtask

  task automatic test_perf_clr();
    do_reset();
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1'b0);
    total++;
    if (load_stall_cnt !== (PERF ? 32'd3 : 32'd0))
      $display("FAIL perf_before_clr: got %0d want %0d", load_stall_cnt, PERF ? 3 : 0);
    else passed++;
    @(negedge clk);
    perf_clr = 1'b1;
    #1;
    total++;
    if (stall !== 6'b000111)
      $display("FAIL perf_clr_stall: stall=%b want 000111", stall);
    else passed++;
    drive(1'b0, 1'b0, 1'b0);
    perf_clr = 1'b0;
    total++;
    if (load_stall_cnt !== 32'd0 || ex_stall_cnt !== 32'd0)
      $display("FAIL perf_after_clr: load=%0d ex=%0d want 0 0", load_stall_cnt, ex_stall_cnt);
    else passed++;
  endtask

  initial begin
    rst = 1'b0; perf_clr = 1'b0;
    stallreq_for_load = 1'b0; stallreq_for_ex = 1'b0; flush_req = 1'b0;
    test_reset();
    test_load_use();
    test_ex_hold();
    test_timeout();
    test_flush();
    test_perf_clr();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Pipeline stall/flush controller. It is the consumer of the load-use stall request produced by the ID-stage forwarding logic, and of the EX-stage multi-cycle busy request.
- Drives the 6-bit stall bus and the flush line sampled by every pipeline register, including the forwarding registers.
- Bit order of the stall bus: [0] PC, [1] IF, [2] ID, [3] EX, [4] MEM, [5] WB. Value 1 means Stop.

Parameters:
- MAX_EX_HOLD, 64, maximum legal consecutive EX-hold cycles before hold_timeout is raised.
- FLUSH_CYCLES, 2, total cycles flush stays asserted per flush request (range 1..15).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-low.
- stallreq_for_load  in  1  load-use hazard request from forwarding logic; combinational, same cycle.
- stallreq_for_ex  in  1  EX multi-cycle unit busy (mul/div).
- flush_req  in  1  exception/redirect flush request, one-cycle pulse or level.
- stall  out  6  stall bus to pipeline registers.
- flush  out  1  flush to all pipeline registers.
- in_load_bubble  out  1  high in the cycle after a load-use stall.
- hold_timeout  out  1  sticky error: EX hold exceeded MAX_EX_HOLD.
- perf_clr  in  1  clears performance counters (used only when STALL_PERF_EN is defined).
- load_stall_cnt  out  32  load-use stall cycles.
- ex_stall_cnt  out  32  EX-hold stall cycles.

Behaviour:
- Reset: while rst=0 at posedge, state<=RUN, counters<=0, hold_timeout<=0. During reset, stall=6'b000000, flush=0, in_load_bubble=0.
- stall and flush are combinational from the current state and the inputs, so they take effect in the same cycle as the request. Only the state, counters and sticky flag are registered.
- Stall encodings:
  - NONE = 000000.
  - LOAD = 000111: PC/IF/ID hold, bubble enters EX.
  - EXH = 001111: PC..EX hold, bubble enters MEM.
- Request priority: flush_req > stallreq_for_ex > stallreq_for_load.
- State RUN:
  - flush_req: flush=1, stall=NONE, flush counter loaded with FLUSH_CYCLES-1. Next state is FLUSH, or RUN if FLUSH_CYCLES=1.
  - else stallreq_for_ex: stall=EXH, hold counter<=1, next state EX_HOLD.
  - else stallreq_for_load: stall=LOAD, next state LOAD_BUB.
  - else stall=NONE.
- State LOAD_BUB (exactly 1 cycle):
  - in_load_bubble=1 and stallreq_for_load is masked, because the load is now in MEM and its data is forwarded.
  - flush_req or stallreq_for_ex is handled exactly as in RUN.
  - Otherwise stall=NONE and next state RUN.
- State EX_HOLD:
  - flush_req aborts the hold: flush=1, stall=NONE, go to the FLUSH path.
  - else if stallreq_for_ex=1: stall=EXH and the hold counter increments, saturating at MAX_EX_HOLD.
  - When the counter equals MAX_EX_HOLD with the request still high, hold_timeout<=1. hold_timeout is sticky until reset.
  - When stallreq_for_ex=0: stall=NONE and next state RUN. A simultaneous stallreq_for_load is ignored that cycle, since the EX instruction was frozen and is re-evaluated next cycle.
- State FLUSH:
  - flush=1, stall=NONE, all stall requests ignored; the counter decrements.
  - Leave to RUN when the counter is 0.
  - A new flush_req while in FLUSH reloads the counter to FLUSH_CYCLES-1.
  - Total flush width is therefore FLUSH_CYCLES cycles from the last request.
- A reset asserted mid-hold or mid-flush immediately forces all outputs to their reset values in that cycle.

Optional Feature:
- Macro STALL_PERF_EN.
- Defined:
  - load_stall_cnt increments in every cycle where stall==LOAD.
  - ex_stall_cnt increments in every cycle where stall==EXH.
  - Both are 32-bit, saturating at 32'hFFFF_FFFF.
  - Both are cleared synchronously by perf_clr=1 or reset; perf_clr has priority over increment.
- Undefined: both outputs are tied to 0 and perf_clr is ignored. Ports remain present.

Test Plan:
- Reset: rst=0 for 3 cycles with all requests high -> stall=000000, flush=0, hold_timeout=0.
- Load-use: stallreq_for_load=1 for 2 cycles from RUN -> cycle0 stall=000111; cycle1 stall=000000 with in_load_bubble=1; cycle2 in RUN with stallreq_for_load=1 -> stall=000111 again.
- EX hold: stallreq_for_ex=1 for 5 cycles with stallreq_for_load also high -> stall=001111 for 5 cycles, then 000000; ex_stall_cnt=5 and load_stall_cnt=0 (with STALL_PERF_EN).
- Timeout: MAX_EX_HOLD=4, stallreq_for_ex held 6 cycles -> hold_timeout rises after the 4th hold cycle and stays 1 after release.
- Flush priority: flush_req=1 during EX_HOLD cycle 2 -> same cycle flush=1 and stall=000000. Flush stays high 2 cycles (FLUSH_CYCLES=2); a second flush_req in the 2nd cycle extends it to 3 cycles total.
- Perf clear: after 3 load stalls, perf_clr=1 together with a load stall -> load_stall_cnt=0 next cycle. With the macro undefined -> both counters read 0 throughout.
